// File: rtl/mpu_mem_xfer.sv
// Load/store engine moving an MxN matrix of FP elements between a memory stream
// and one register-file slot, with optional transpose and a 2-entry store FIFO.
module mpu_mem_xfer #(
    parameter int FPBITS   = 31,
    parameter int M_MAX    = 3,
    parameter int N_MAX    = 3,
    parameter int NUM_REGS = 4,
    localparam int AW = $clog2(NUM_REGS),
    localparam int MW = $clog2(M_MAX + 1),
    localparam int NW = $clog2(N_MAX + 1),
    localparam int IW = $clog2((M_MAX > N_MAX) ? M_MAX : N_MAX),
    localparam int EW = FPBITS + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en_in,
    input  logic          store_en_in,
    input  logic [AW-1:0] addr_in,
    input  logic [MW-1:0] m_in,
    input  logic [NW-1:0] n_in,
    input  logic          transpose_in,
    output logic          busy_out,
    output logic          done_out,
    output logic          error_out,
    input  logic [EW-1:0] mem_load_element_in,
    input  logic          mem_load_valid_in,
    output logic          mem_load_ready_out,
    output logic [EW-1:0] mem_store_element_out,
    output logic          mem_store_valid_out,
    output logic          mem_store_last_out,
    input  logic          mem_store_ready_in,
    output logic          reg_wr_en_out,
    output logic          reg_rd_en_out,
    output logic [AW-1:0] reg_addr_out,
    output logic [IW-1:0] reg_i_out,
    output logic [IW-1:0] reg_j_out,
    output logic [EW-1:0] reg_wr_element_out,
    output logic [MW-1:0] reg_m_size_out,
    output logic [NW-1:0] reg_n_size_out,
    input  logic [EW-1:0] reg_rd_element_in
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [MW-1:0] m_q, m_d, r_q, r_d;
    logic [NW-1:0] n_q, n_d, c_q, c_d;
    logic          tr_q, tr_d;
    logic          err_q, err_d;
    logic          issued_all_q, issued_all_d;
    logic          infl_q, infl_d, infl_last_q, infl_last_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [EW-1:0] f0_q, f0_d, f1_q, f1_d;
    logic          l0_q, l0_d, l1_q, l1_d;

    logic size_ok, start_ok, c_last, at_end;
    logic load_hs, rd_issue, strobe, st_valid, pop, head_last;
    logic [EW-1:0] head_data;

    assign size_ok  = (m_in != '0) && ({1'b0, m_in} <= (MW+1)'(M_MAX)) &&
                      (n_in != '0) && ({1'b0, n_in} <= (NW+1)'(N_MAX));
    assign start_ok = (load_en_in ^ store_en_in) && size_ok;
    assign c_last   = (c_q == n_q - NW'(1));
    assign at_end   = c_last && (r_q == m_q - MW'(1));

    assign load_hs  = (state_q == S_LOAD) && mem_load_valid_in;
    // Occupancy plus the read still in flight must leave room for the new element.
    assign rd_issue = (state_q == S_STORE) && !issued_all_q &&
                      ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && !infl_q));
    assign strobe   = load_hs || rd_issue;

    // Data returning from the register file is visible at the head the cycle it arrives.
    assign st_valid  = (cnt_q != 2'd0) || infl_q;
    assign head_data = (cnt_q != 2'd0) ? f0_q : reg_rd_element_in;
    assign head_last = (cnt_q != 2'd0) ? l0_q : infl_last_q;
    assign pop       = st_valid && mem_store_ready_in;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        m_d          = m_q;
        n_d          = n_q;
        tr_d         = tr_q;
        r_d          = r_q;
        c_d          = c_q;
        err_d        = 1'b0;
        issued_all_d = issued_all_q;
        infl_d       = rd_issue;
        infl_last_d  = rd_issue && at_end;
        f0_d         = f0_q;
        f1_d         = f1_q;
        l0_d         = l0_q;
        l1_d         = l1_q;
        cnt_d        = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (load_en_in || store_en_in) begin
                    if (start_ok) begin
                        addr_d       = addr_in;
                        m_d          = m_in;
                        n_d          = n_in;
                        tr_d         = transpose_in;
                        r_d          = '0;
                        c_d          = '0;
                        issued_all_d = 1'b0;
                        state_d      = load_en_in ? S_LOAD : S_STORE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD:  if (load_hs && at_end) state_d = S_DONE;
            S_STORE: if (pop && head_last) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        if (strobe) begin
            if (c_last) begin
                c_d = '0;
                r_d = r_q + MW'(1);
            end else begin
                c_d = c_q + NW'(1);
            end
            if (rd_issue && at_end) issued_all_d = 1'b1;
        end

        // FIFO: shift on pop, append the returning element behind what remains.
        if (pop && cnt_q != 2'd0) begin
            f0_d  = f1_q;
            l0_d  = l1_q;
            cnt_d = cnt_q - 2'd1;
            if (infl_q) begin
                cnt_d = cnt_q;
                if (cnt_q == 2'd1) begin
                    f0_d = reg_rd_element_in;
                    l0_d = infl_last_q;
                end else begin
                    f1_d = reg_rd_element_in;
                    l1_d = infl_last_q;
                end
            end
        end else if (!pop && infl_q) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd0) begin
                f0_d = reg_rd_element_in;
                l0_d = infl_last_q;
            end else begin
                f1_d = reg_rd_element_in;
                l1_d = infl_last_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            m_q          <= '0;
            n_q          <= '0;
            tr_q         <= 1'b0;
            r_q          <= '0;
            c_q          <= '0;
            err_q        <= 1'b0;
            issued_all_q <= 1'b0;
            infl_q       <= 1'b0;
            infl_last_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            m_q          <= m_d;
            n_q          <= n_d;
            tr_q         <= tr_d;
            r_q          <= r_d;
            c_q          <= c_d;
            err_q        <= err_d;
            issued_all_q <= issued_all_d;
            infl_q       <= infl_d;
            infl_last_q  <= infl_last_d;
            cnt_q        <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        f0_q <= f0_d;
        f1_q <= f1_d;
        l0_q <= l0_d;
        l1_q <= l1_d;
    end

    assign busy_out              = (state_q != S_IDLE);
    assign done_out              = (state_q == S_DONE);
    assign error_out             = err_q;
    assign mem_load_ready_out    = (state_q == S_LOAD);
    assign mem_store_valid_out   = st_valid;
    assign mem_store_element_out = st_valid ? head_data : '0;
    assign mem_store_last_out    = st_valid && head_last;
    assign reg_wr_en_out         = load_hs;
    assign reg_rd_en_out         = rd_issue;
    assign reg_addr_out          = strobe ? addr_q : '0;
    assign reg_i_out             = strobe ? (tr_q ? IW'(c_q) : IW'(r_q)) : '0;
    assign reg_j_out             = strobe ? (tr_q ? IW'(r_q) : IW'(c_q)) : '0;
    assign reg_wr_element_out    = load_hs ? mem_load_element_in : '0;
    assign reg_m_size_out        = load_hs ? (tr_q ? MW'(n_q) : m_q) : '0;
    assign reg_n_size_out        = load_hs ? (tr_q ? NW'(m_q) : n_q) : '0;

endmodule

// File: tb/tb_mpu_mem_xfer.sv
// Directed bench for mpu_mem_xfer: load/store, transpose, backpressure, errors, reset.
module tb_mpu_mem_xfer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en_in, store_en_in, transpose_in;
    logic [1:0]  addr_in, m_in, n_in;
    logic        busy_out, done_out, error_out;
    logic [31:0] mem_load_element_in;
    logic        mem_load_valid_in, mem_load_ready_out;
    logic [31:0] mem_store_element_out;
    logic        mem_store_valid_out, mem_store_last_out, mem_store_ready_in;
    logic        reg_wr_en_out, reg_rd_en_out;
    logic [1:0]  reg_addr_out, reg_i_out, reg_j_out, reg_m_size_out, reg_n_size_out;
    logic [31:0] reg_wr_element_out, reg_rd_element_in;

    int checks = 0;
    int errors = 0;

    // Single-precision bit patterns of the test-plan values, element 0..8.
    logic [31:0] vals [9] = '{32'h3F800000, 32'h4249519A, 32'hC0200000,
                              32'h3E000000, 32'hBEAAAAA0, 32'h4E932C06,
                              32'h00000000, 32'hB6A7C5AC, 32'hD0132D05};
    // 2x3 load (0x100+k) transposed, then read back as 3x2 untransposed.
    logic [31:0] bp_exp [6] = '{32'h100, 32'h103, 32'h101, 32'h104, 32'h102, 32'h105};
    logic [31:0] rf [4][4][4];

    mpu_mem_xfer dut (
        .clk(clk), .rst(rst),
        .load_en_in(load_en_in), .store_en_in(store_en_in),
        .addr_in(addr_in), .m_in(m_in), .n_in(n_in), .transpose_in(transpose_in),
        .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
        .mem_load_element_in(mem_load_element_in), .mem_load_valid_in(mem_load_valid_in),
        .mem_load_ready_out(mem_load_ready_out),
        .mem_store_element_out(mem_store_element_out), .mem_store_valid_out(mem_store_valid_out),
        .mem_store_last_out(mem_store_last_out), .mem_store_ready_in(mem_store_ready_in),
        .reg_wr_en_out(reg_wr_en_out), .reg_rd_en_out(reg_rd_en_out),
        .reg_addr_out(reg_addr_out), .reg_i_out(reg_i_out), .reg_j_out(reg_j_out),
        .reg_wr_element_out(reg_wr_element_out),
        .reg_m_size_out(reg_m_size_out), .reg_n_size_out(reg_n_size_out),
        .reg_rd_element_in(reg_rd_element_in)
    );

    always #5 clk = ~clk;

    // Register-file model: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (reg_wr_en_out) rf[reg_addr_out][reg_i_out][reg_j_out] <= reg_wr_element_out;
        if (reg_rd_en_out) reg_rd_element_in <= rf[reg_addr_out][reg_i_out][reg_j_out];
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy_out), 0);
        chk({tag, "_done"}, 64'(done_out), 0);
        chk({tag, "_ready"}, 64'(mem_load_ready_out), 0);
        chk({tag, "_valid"}, 64'(mem_store_valid_out), 0);
        chk({tag, "_last"}, 64'(mem_store_last_out), 0);
        chk({tag, "_strobes"}, 64'({reg_wr_en_out, reg_rd_en_out}), 0);
        chk({tag, "_sdata"}, 64'(mem_store_element_out), 0);
        chk({tag, "_addr"}, 64'(reg_addr_out), 0);
    endtask

    // Full 3x3 untransposed load with continuous valid; element k carries data[k].
    task automatic load_full(input string tag, input logic [1:0] slot, input logic rev);
        addr_in = slot; m_in = 2'd3; n_in = 2'd3; transpose_in = 1'b0;
        load_en_in = 1'b1;
        step();
        load_en_in = 1'b0;
        for (int k = 0; k < 9; k++) begin
            mem_load_valid_in   = 1'b1;
            mem_load_element_in = rev ? vals[8-k] : vals[k];
            #1;
            if (k == 0) begin
                chk({tag, "_busy"}, 64'(busy_out), 1);
                chk({tag, "_msize"}, 64'(reg_m_size_out), 3);
                chk({tag, "_nsize"}, 64'(reg_n_size_out), 3);
            end
            chk({tag, "_wr_en"}, 64'(reg_wr_en_out), 1);
            chk({tag, "_wdata"}, 64'(reg_wr_element_out), 64'(rev ? vals[8-k] : vals[k]));
            chk({tag, "_ij"}, 64'({reg_i_out, reg_j_out}), 64'({2'(k / 3), 2'(k % 3)}));
            chk({tag, "_slot"}, 64'(reg_addr_out), 64'(slot));
            chk({tag, "_no_done"}, 64'(done_out), 0);
            step();
        end
        mem_load_valid_in = 1'b0;
        #1;
        chk({tag, "_done"}, 64'(done_out), 1);
        chk({tag, "_wr_off"}, 64'(reg_wr_en_out), 0);
        step();
        chk({tag, "_done_1cyc"}, 64'(done_out), 0);
        chk({tag, "_idle"}, 64'(busy_out), 0);
    endtask

    initial begin
        int got, e, reads, pops, cyc;
        logic prev_stall, saw_done, last_hs;
        logic [31:0] prev_data;

        rst = 1'b1; load_en_in = 1'b0; store_en_in = 1'b0; transpose_in = 1'b0;
        addr_in = '0; m_in = '0; n_in = '0;
        mem_load_element_in = '0; mem_load_valid_in = 1'b0; mem_store_ready_in = 1'b0;
        step(); step();
        quiet_outputs("reset");
        chk("reset_error", 64'(error_out), 0);
        rst = 1'b0;
        step();

        // 3x3 load into slot 0, then store it back with ready held high.
        load_full("ld33", 2'd0, 1'b0);

        mem_store_ready_in = 1'b1;
        addr_in = 2'd0; m_in = 2'd3; n_in = 2'd3; transpose_in = 1'b0;
        store_en_in = 1'b1;
        step();
        store_en_in = 1'b0;
        #1;
        chk("st33_busy", 64'(busy_out), 1);
        chk("st33_first_rd", 64'(reg_rd_en_out), 1);
        chk("st33_no_valid_yet", 64'(mem_store_valid_out), 0);
        step();
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("st33_valid", 64'(mem_store_valid_out), 1);
            chk("st33_data", 64'(mem_store_element_out), 64'(vals[k]));
            chk("st33_last", 64'(mem_store_last_out), 64'(k == 8));
            chk("st33_no_done", 64'(done_out), 0);
            step();
        end
        #1;
        chk("st33_done", 64'(done_out), 1);
        chk("st33_valid_off", 64'(mem_store_valid_out), 0);
        step();
        chk("st33_idle", 64'(busy_out), 0);

        // 2x3 transposed load into slot 1 with valid gaps and a stray start while busy.
        addr_in = 2'd1; m_in = 2'd2; n_in = 2'd3; transpose_in = 1'b1;
        load_en_in = 1'b1;
        step();
        load_en_in = 1'b0; transpose_in = 1'b0;
        got = 0; cyc = 0;
        while (got < 6 && cyc < 30) begin
            mem_load_valid_in   = (cyc % 3 != 1);
            mem_load_element_in = 32'h100 + 32'(got);
            store_en_in         = (cyc == 0);
            #1;
            if (cyc == 1) chk("ldtr_busy_start_no_err", 64'(error_out), 0);
            if (mem_load_valid_in) begin
                chk("ldtr_wr_en", 64'(reg_wr_en_out), 1);
                chk("ldtr_wdata", 64'(reg_wr_element_out), 64'(32'h100 + 32'(got)));
                chk("ldtr_ij", 64'({reg_i_out, reg_j_out}), 64'({2'(got % 3), 2'(got / 3)}));
                if (got == 1) begin
                    chk("ldtr_msize", 64'(reg_m_size_out), 3);
                    chk("ldtr_nsize", 64'(reg_n_size_out), 2);
                end
                got++;
            end else begin
                chk("ldtr_gap_no_wr", 64'(reg_wr_en_out), 0);
            end
            step();
            cyc++;
        end
        store_en_in = 1'b0; mem_load_valid_in = 1'b0;
        chk("ldtr_count", 64'(got), 6);
        #1;
        chk("ldtr_done", 64'(done_out), 1);
        step();
        chk("ldtr_idle", 64'(busy_out), 0);

        // Store slot 1 as 3x2 with ready pattern 1,0,0,1.
        addr_in = 2'd1; m_in = 2'd3; n_in = 2'd2; transpose_in = 1'b0;
        store_en_in = 1'b1;
        step();
        store_en_in = 1'b0;
        e = 0; reads = 0; pops = 0; prev_stall = 1'b0; saw_done = 1'b0; last_hs = 1'b0;
        prev_data = '0;
        for (int c = 0; c < 60 && !saw_done; c++) begin
            mem_store_ready_in = (c % 4 == 0) || (c % 4 == 3);
            #1;
            if (done_out) begin
                chk("stbp_count", 64'(e), 6);
                chk("stbp_done_after_last", 64'(last_hs), 1);
                saw_done = 1'b1;
            end else begin
                if (prev_stall) begin
                    chk("stbp_hold_valid", 64'(mem_store_valid_out), 1);
                    chk("stbp_hold_data", 64'(mem_store_element_out), 64'(prev_data));
                end
                if (reg_rd_en_out) begin
                    chk("stbp_outstanding", 64'((reads - pops) < 2), 1);
                    reads++;
                end
                if (mem_store_valid_out) begin
                    if (e < 6) begin
                        chk("stbp_data", 64'(mem_store_element_out), 64'(bp_exp[e]));
                        chk("stbp_last", 64'(mem_store_last_out), 64'(e == 5));
                    end else begin
                        chk("stbp_extra", 64'(mem_store_valid_out), 0);
                    end
                end
                last_hs    = mem_store_valid_out && mem_store_ready_in;
                prev_stall = mem_store_valid_out && !mem_store_ready_in;
                prev_data  = mem_store_element_out;
                if (last_hs) begin
                    e++;
                    pops++;
                end
            end
            step();
        end
        chk("stbp_finished", 64'(saw_done), 1);
        chk("stbp_reads", 64'(reads), 6);
        chk("stbp_idle", 64'(busy_out), 0);

        // Invalid starts: m=0, n=N_MAX+1 (wraps to 0 in 2 bits), both enables.
        for (int t = 0; t < 3; t++) begin
            m_in = (t == 0) ? 2'd0 : 2'd3;
            n_in = (t == 1) ? 2'd0 : 2'd3;
            load_en_in  = 1'b1;
            store_en_in = (t == 2);
            step();
            load_en_in = 1'b0; store_en_in = 1'b0;
            #1;
            chk("err_pulse", 64'(error_out), 1);
            chk("err_busy", 64'(busy_out), 0);
            chk("err_strobes", 64'({reg_wr_en_out, reg_rd_en_out, mem_load_ready_out}), 0);
            step();
            chk("err_one_cycle", 64'(error_out), 0);
            chk("err_still_idle", 64'(busy_out), 0);
        end

        // Reset in the middle of a 3x3 store after 4 elements.
        mem_store_ready_in = 1'b1;
        addr_in = 2'd0; m_in = 2'd3; n_in = 2'd3; transpose_in = 1'b0;
        store_en_in = 1'b1;
        step();
        store_en_in = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rstst_data", 64'(mem_store_element_out), 64'(vals[k]));
            if (k == 3) rst = 1'b1;
            step();
        end
        quiet_outputs("rstst");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rstst_no_done", 64'(done_out), 0);
            chk("rstst_no_valid", 64'(mem_store_valid_out), 0);
        end

        load_full("ld_after_rst", 2'd2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
